// File: rtl/instruction_memory.sv
// instruction_memory: 256x32 preloadable word store answering 128-bit block reads after READ_LATENCY cycles
module instruction_memory #(
  parameter int READ_LATENCY = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inst_read,
  input  logic [5:0]   inst_address,
  output logic [127:0] inst_readdata,
  output logic         inst_BUSY,
  input  logic         load_en,
  input  logic [7:0]   load_addr,
  input  logic [31:0]  load_data
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t      r_state, w_next;
  logic [31:0] r_mem [256];
  logic [3:0]  r_cnt;
  logic [5:0]  r_req_addr;
  logic        w_done;
  // The load port has no reset so a program survives reset of the FSM
  always_ff @(posedge clock)
    if (load_en) r_mem[load_addr] <= load_data;
  assign w_done = r_state == ACCESS && r_cnt == 4'd0;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = inst_read ? ACCESS : IDLE;
      ACCESS:  w_next = w_done ? RESP : ACCESS;
      RESP:    w_next = inst_read ? RESP : IDLE;
      default: w_next = IDLE;
    endcase
  end
  // IDLE term lets the cache see BUSY on the very first edge of its request
  assign inst_BUSY = (r_state == IDLE && inst_read) || r_state == ACCESS;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      r_state       <= IDLE;
      r_cnt         <= 4'd0;
      r_req_addr    <= 6'd0;
      inst_readdata <= 128'd0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && inst_read) begin
        r_req_addr <= inst_address;
        r_cnt      <= 4'(READ_LATENCY - 1);
      end
      if (r_state == ACCESS && r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
      if (w_done)
        inst_readdata <= {r_mem[{r_req_addr, 2'd3}], r_mem[{r_req_addr, 2'd2}],
                          r_mem[{r_req_addr, 2'd1}], r_mem[{r_req_addr, 2'd0}]};
    end
endmodule
